data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
Two-port round-robin arbiter that shares the single-port data memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader). Each requester uses a req/gnt handshake. The arbiter sequences one memory access at a time and returns read data with a registered valid pulse. It sits between the requesters and the data memory's mem_write/address/write_data/read_data pins.

Parameters:
ADDR_WIDTH, 16, width of address buses (matches data memory address port)
DATA_WIDTH, 16, width of data buses
DEPTH, 16, number of implemented memory words (used only by ADDR_CHECK_EN)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
r0_req  input  1  requester 0 access request; held with r0_we/r0_addr/r0_wdata stable until r0_gnt
r0_we  input  1  requester 0: 1 = write, 0 = read
r0_addr  input  ADDR_WIDTH  requester 0 address
r0_wdata  input  DATA_WIDTH  requester 0 write data
r0_gnt  output  1  one-cycle pulse: request 0 accepted
r0_rvalid  output  1  one-cycle pulse: r0_rdata holds read result
r0_rdata  output  DATA_WIDTH  requester 0 read data, held until next r0 read completes
r0_err  output  1  one-cycle pulse, out-of-range access (ADDR_CHECK_EN only)
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err  same as r0_* for requester 1
mem_write  output  1  to data memory mem_write
mem_address  output  ADDR_WIDTH  to data memory address
mem_write_data  output  DATA_WIDTH  to data memory write_data
mem_read_data  input  DATA_WIDTH  from data memory read_data (valid one cycle after a read edge)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; rN_rdata=0; command registers 0; rr_last=1 (requester 0 wins first tie).
- States: IDLE, ISSUE, RESP.
- IDLE: if no req, stay. Else pick winner: single requester wins; both requesting -> requester != rr_last. On the edge: latch winner's we/addr/wdata into cmd regs, set cmd_id, rr_last=winner, go to ISSUE.
- ISSUE (1 cycle): rN_gnt=1 for cmd_id only; mem_address=cmd_addr; mem_write_data=cmd_wdata; mem_write=cmd_we. Next: write -> IDLE; read -> RESP.
- RESP (1 cycle): mem_address held; mem_write=0; at edge capture mem_read_data into rN_rdata of cmd_id, pulse rN_rvalid next cycle; go to IDLE.
- rvalid pulse overlaps the following IDLE cycle; a new arbitration may occur in that cycle.
- Latency from req sampled in IDLE (cycle 0): gnt cycle 1; write lands at end of cycle 1; read rvalid cycle 3. Throughput: write every 2 cycles, read every 3.
- Requester must drop req the cycle after gnt; a req still high in IDLE is a new request.
- mem_write is 0 in every state except ISSUE with cmd_we=1. mem_address/mem_write_data hold last cmd values outside ISSUE.
- Continuous requests from both: grants strictly alternate 0,1,0,1.
- Reset mid-operation: asynchronously clears mem_write; a write in ISSUE when reset rises is not performed; a pending read produces no rvalid.
- Widths: no arithmetic; addresses passed unmodified (except under ADDR_CHECK_EN).

Optional Feature:
DATA_MEMORY_ARBITER_ADDR_CHECK_EN: when defined, cmd_addr >= DEPTH is out of range. Write: mem_write held 0 in ISSUE, rN_err pulses the cycle after ISSUE. Read: captured rN_rdata forced to 0, rN_err pulses together with rN_rvalid. gnt timing unchanged. When undefined: rN_err tied 0, all addresses passed through unchecked.

Test Plan:
Reset then r0 write addr 3 data 0xBEEF -> r0_gnt cycle 1, mem_write=1 with address 3 data 0xBEEF in cycle 1 only, busy 1 cycle 1, IDLE cycle 2.
r0 read addr 3 after above -> r0_gnt cycle 1, r0_rvalid cycle 3, r0_rdata=0xBEEF, r1_rvalid stays 0.
r0 and r1 both request reads from reset, held until granted -> r0 granted first, r1 granted 3 cycles later; rdata routed to correct requester.
Both requesters issue back-to-back writes for 8 grants -> gnt sequence 0,1,0,1,0,1,0,1, no two consecutive grants to the same requester.
Assert reset during ISSUE of r1 write addr 5 data 0x1234 -> mem_write drops immediately, memory word 5 unchanged, all outputs 0.
With ADDR_CHECK_EN: r0 write addr 16 -> mem_write stays 0, r0_err pulse cycle 2; r0 read addr 20 -> r0_rdata=0, r0_err and r0_rvalid in cycle 3.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two req/gnt requesters.
// Optional out-of-range address checking is enabled with DATA_MEMORY_ARBITER_ADDR_CHECK_EN.
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  busy
);

`ifdef DATA_MEMORY_ARBITER_ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif
    localparam int unsigned CmpWidth = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e                state_q;
    logic                  cmd_we_q;
    logic                  cmd_id_q;
    logic                  cmd_oor_q;
    logic                  rr_last_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic                  mem_write_q;
    logic [1:0]            gnt_q;
    logic [1:0]            rvalid_q;
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] r0_rdata_q;
    logic [DATA_WIDTH-1:0] r1_rdata_q;

    logic                  any_req;
    logic                  win_id;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_oor;

    // On a tie the requester that did not win last time goes next.
    assign any_req   = r0_req | r1_req;
    assign win_id    = (r0_req && r1_req) ? ~rr_last_q : r1_req;
    assign win_we    = win_id ? r1_we    : r0_we;
    assign win_addr  = win_id ? r1_addr  : r0_addr;
    assign win_wdata = win_id ? r1_wdata : r0_wdata;
    assign win_oor   = AddrCheck && ({1'b0, win_addr} >= CmpWidth'(DEPTH));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_id_q    <= 1'b0;
            cmd_oor_q   <= 1'b0;
            rr_last_q   <= 1'b1;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            mem_write_q <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        cmd_we_q       <= win_we;
                        cmd_id_q       <= win_id;
                        cmd_oor_q      <= win_oor;
                        cmd_addr_q     <= win_addr;
                        cmd_wdata_q    <= win_wdata;
                        rr_last_q      <= win_id;
                        gnt_q[win_id]  <= 1'b1;
                        mem_write_q    <= win_we & ~win_oor;
                        state_q        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_we_q) begin
                        err_q[cmd_id_q] <= cmd_oor_q;
                        state_q         <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (cmd_id_q) begin
                        r1_rdata_q <= cmd_oor_q ? '0 : mem_read_data;
                    end else begin
                        r0_rdata_q <= cmd_oor_q ? '0 : mem_read_data;
                    end
                    rvalid_q[cmd_id_q] <= 1'b1;
                    err_q[cmd_id_q]    <= cmd_oor_q;
                    state_q            <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_gnt         = gnt_q[0];
    assign r1_gnt         = gnt_q[1];
    assign r0_rvalid      = rvalid_q[0];
    assign r1_rvalid      = rvalid_q[1];
    assign r0_err         = err_q[0];
    assign r1_err         = err_q[1];
    assign r0_rdata       = r0_rdata_q;
    assign r1_rdata       = r1_rdata_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = cmd_addr_q;
    assign mem_write_data = cmd_wdata_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: cycle table plus alternation, reset and address-check sequences.
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [15:0] r0_addr = '0, r0_wdata = '0;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [15:0] r1_addr = '0, r1_wdata = '0;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [15:0] r0_rdata, r1_rdata;
    logic        mem_write, busy;
    logic [15:0] mem_address, mem_write_data, mem_read_data;

    int n_cmp  = 0;
    int n_fail = 0;

    data_memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(16)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous single-port memory model, word i preloaded with 0x1000+i.
    logic [15:0] mem [32];
    bit          mem_init_done;
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address[4:0]] <= mem_write_data;
        end
        mem_read_data <= mem[mem_address[4:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        r0_req, r0_we;
        logic [15:0] r0_addr, r0_wdata;
        logic        r1_req, r1_we;
        logic [15:0] r1_addr, r1_wdata;
        logic [1:0]  gnt, rvalid;
        logic        mw;
        logic [15:0] maddr;
        logic        busy;
        logic [15:0] r0_rdata, r1_rdata;
    } vec_t;

    function automatic vec_t v(input logic rst,
                               input logic q0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                               input logic q1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                               input logic [1:0] gnt, input logic [1:0] rvalid, input logic mw,
                               input logic [15:0] maddr, input logic bsy,
                               input logic [15:0] rd0, input logic [15:0] rd1);
        vec_t t;
        t.rst = rst;
        t.r0_req = q0; t.r0_we = w0; t.r0_addr = a0; t.r0_wdata = d0;
        t.r1_req = q1; t.r1_we = w1; t.r1_addr = a1; t.r1_wdata = d1;
        t.gnt = gnt; t.rvalid = rvalid; t.mw = mw; t.maddr = maddr; t.busy = bsy;
        t.r0_rdata = rd0; t.r1_rdata = rd1;
        return t;
    endfunction

    vec_t tbl [16];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ng;
        int last_cyc;
        logic [1:0] exp_g;

        // Cycle table: each row gives inputs for a cycle and the outputs expected in that same cycle.
        tbl[0]  = v(0, 1,1,16'd3,16'hBEEF, 0,0,0,0, 2'b00,2'b00,0,16'd0,0, 16'h0,16'h0);
        tbl[1]  = v(0, 1,1,16'd3,16'hBEEF, 0,0,0,0, 2'b01,2'b00,1,16'd3,1, 16'h0,16'h0);
        tbl[2]  = v(0, 0,0,0,0,            0,0,0,0, 2'b00,2'b00,0,16'd3,0, 16'h0,16'h0);
        tbl[3]  = v(0, 1,0,16'd3,0,        0,0,0,0, 2'b00,2'b00,0,16'd3,0, 16'h0,16'h0);
        tbl[4]  = v(0, 1,0,16'd3,0,        0,0,0,0, 2'b01,2'b00,0,16'd3,1, 16'h0,16'h0);
        tbl[5]  = v(0, 0,0,0,0,            0,0,0,0, 2'b00,2'b00,0,16'd3,1, 16'h0,16'h0);
        tbl[6]  = v(0, 0,0,0,0,            0,0,0,0, 2'b00,2'b01,0,16'd3,0, 16'hBEEF,16'h0);
        tbl[7]  = v(0, 0,0,0,0,            0,0,0,0, 2'b00,2'b00,0,16'd3,0, 16'hBEEF,16'h0);
        tbl[8]  = v(1, 0,0,0,0,            0,0,0,0, 2'b00,2'b00,0,16'd0,0, 16'h0,16'h0);
        tbl[9]  = v(0, 1,0,16'd7,0,        1,0,16'd9,0, 2'b00,2'b00,0,16'd0,0, 16'h0,16'h0);
        tbl[10] = v(0, 1,0,16'd7,0,        1,0,16'd9,0, 2'b01,2'b00,0,16'd7,1, 16'h0,16'h0);
        tbl[11] = v(0, 0,0,0,0,            1,0,16'd9,0, 2'b00,2'b00,0,16'd7,1, 16'h0,16'h0);
        tbl[12] = v(0, 0,0,0,0,            1,0,16'd9,0, 2'b00,2'b01,0,16'd7,0, 16'h1007,16'h0);
        tbl[13] = v(0, 0,0,0,0,            1,0,16'd9,0, 2'b10,2'b00,0,16'd9,1, 16'h1007,16'h0);
        tbl[14] = v(0, 0,0,0,0,            0,0,0,0, 2'b00,2'b00,0,16'd9,1, 16'h1007,16'h0);
        tbl[15] = v(0, 0,0,0,0,            0,0,0,0, 2'b00,2'b10,0,16'd9,0, 16'h1007,16'h1009);

        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            reset = tbl[i].rst;
            r0_req = tbl[i].r0_req; r0_we = tbl[i].r0_we; r0_addr = tbl[i].r0_addr; r0_wdata = tbl[i].r0_wdata;
            r1_req = tbl[i].r1_req; r1_we = tbl[i].r1_we; r1_addr = tbl[i].r1_addr; r1_wdata = tbl[i].r1_wdata;
            #1;
            chk($sformatf("row%0d_gnt", i),    32'({r1_gnt, r0_gnt}), 32'(tbl[i].gnt));
            chk($sformatf("row%0d_rvalid", i), 32'({r1_rvalid, r0_rvalid}), 32'(tbl[i].rvalid));
            chk($sformatf("row%0d_mem_write", i), 32'(mem_write), 32'(tbl[i].mw));
            chk($sformatf("row%0d_mem_address", i), 32'(mem_address), 32'(tbl[i].maddr));
            chk($sformatf("row%0d_busy", i),   32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_r0_rdata", i), 32'(r0_rdata), 32'(tbl[i].r0_rdata));
            chk($sformatf("row%0d_r1_rdata", i), 32'(r1_rdata), 32'(tbl[i].r1_rdata));
            chk($sformatf("row%0d_err", i),    32'({r1_err, r0_err}), 32'd0);
        end

        // Both requesters hold write requests: grants must alternate 0,1,0,1 every two cycles.
        @(negedge clock);
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 16'd1; r0_wdata = 16'hA1A1;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 16'd2; r1_wdata = 16'hB2B2;
        ng = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
            #1;
            if (r0_gnt || r1_gnt) begin
                exp_g = (ng % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("alt_gnt%0d", ng), 32'({r1_gnt, r0_gnt}), 32'(exp_g));
                chk($sformatf("alt_mem_write%0d", ng), 32'(mem_write), 32'd1);
                if (ng > 0) chk($sformatf("alt_spacing%0d", ng), 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                ng++;
            end
            @(negedge clock);
        end
        chk("alt_grant_count", 32'(ng), 32'd8);
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clock);
        #1;
        chk("alt_idle", 32'(busy), 32'd0);
        chk("alt_mem1", 32'(mem[1]), 32'h0000A1A1);
        chk("alt_mem2", 32'(mem[2]), 32'h0000B2B2);

        // Reset rising during the ISSUE cycle of an r1 write must suppress the write.
        @(negedge clock);
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 16'd5; r1_wdata = 16'h1234;
        @(negedge clock);
        #1;
        chk("rst_issue_gnt", 32'(r1_gnt), 32'd1);
        chk("rst_issue_mem_write", 32'(mem_write), 32'd1);
        chk("rst_issue_addr", 32'(mem_address), 32'd5);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", 32'(mem_write_data), 32'd0);
        chk("rst_rdata", 32'({r1_rdata, r0_rdata}), 32'd0);
        @(negedge clock);
        chk("rst_mem5", 32'(mem[5]), 32'h00001005);
        r1_req = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk("rst_after_rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);

`ifdef DATA_MEMORY_ARBITER_ADDR_CHECK_EN
        // Out-of-range write is suppressed and flagged; out-of-range read returns zero with err.
        @(negedge clock);
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 16'd16; r0_wdata = 16'h5555;
        @(negedge clock);
        #1;
        chk("oor_w_gnt", 32'(r0_gnt), 32'd1);
        chk("oor_w_mem_write", 32'(mem_write), 32'd0);
        r0_req = 1'b0;
        @(negedge clock);
        #1;
        chk("oor_w_err", 32'(r0_err), 32'd1);
        chk("oor_w_mem16", 32'(mem[16]), 32'h00001010);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'd20;
        @(negedge clock);
        #1;
        chk("oor_r_gnt", 32'(r0_gnt), 32'd1);
        chk("oor_r_err_early", 32'(r0_err), 32'd0);
        r0_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("oor_r_rvalid", 32'(r0_rvalid), 32'd1);
        chk("oor_r_err", 32'(r0_err), 32'd1);
        chk("oor_r_rdata", 32'(r0_rdata), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
